// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus/capture engine for a combinational DUT with true (F) and complement (Fn) outputs.
// Optional expected-table comparison is enabled by defining TTS_EXPECT_CHECK_EN.
module truth_table_sweeper #(
  parameter int unsigned N_IN        = 3,
  parameter int unsigned HOLD_CYCLES = 50
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic [N_IN-1:0]        pattern,
  input  logic                   f_in,
  input  logic                   fn_in,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   minterm_mask,
  output logic [N_IN:0]          ones_count,
  output logic                   comp_err,
  output logic [N_IN:0]          err_count
`ifdef TTS_EXPECT_CHECK_EN
  ,
  input  logic [(1<<N_IN)-1:0]   expect_mask,
  output logic                   match,
  output logic [(1<<N_IN)-1:0]   mismatch_mask
`endif
);

  localparam int unsigned NPAT      = 1 << N_IN;
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [15:0]       hold_cnt;
  logic              sample;
  logic              last;
  logic              launch;
  logic [NPAT-1:0]   mask_upd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    sample     = (state == S_DRIVE) && (hold_cnt == HOLD_LAST);
    last       = (pattern == '1);
    launch     = start && !abort && (state != S_DRIVE);
    busy       = (state == S_DRIVE);
    done       = (state == S_DONE);
    // Mask including the sample being taken this cycle, so DONE-entry compare sees the final bit.
    mask_upd          = minterm_mask;
    mask_upd[pattern] = f_in;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) state_next = S_DRIVE;
        S_DRIVE:        if (sample && last) state_next = S_DONE;
        default:        state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern      <= '0;
      hold_cnt     <= '0;
      minterm_mask <= '0;
      ones_count   <= '0;
      comp_err     <= 1'b0;
      err_count    <= '0;
    end else if (abort) begin
      pattern  <= '0;
      hold_cnt <= '0;
    end else if (launch) begin
      pattern      <= '0;
      hold_cnt     <= '0;
      minterm_mask <= '0;
      ones_count   <= '0;
      comp_err     <= 1'b0;
      err_count    <= '0;
    end else if (state == S_DRIVE) begin
      if (sample) begin
        minterm_mask <= mask_upd;
        ones_count   <= ones_count + {{N_IN{1'b0}}, f_in};
        if (fn_in == f_in) begin
          err_count <= err_count + 1'b1;
          comp_err  <= 1'b1;
        end
        hold_cnt <= '0;
        if (!last) pattern <= pattern + 1'b1;
      end else begin
        hold_cnt <= hold_cnt + 16'd1;
      end
    end
  end

`ifdef TTS_EXPECT_CHECK_EN
  logic [NPAT-1:0] expect_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expect_q      <= '0;
      match         <= 1'b0;
      mismatch_mask <= '0;
    end else if (launch) begin
      expect_q      <= expect_mask;
      match         <= 1'b0;
      mismatch_mask <= '0;
    end else if (!abort && sample && last) begin
      mismatch_mask <= mask_upd ^ expect_q;
      match         <= ((mask_upd ^ expect_q) == '0);
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: a default 3-input sweeper driving a majority model and a 4-input, 1-cycle-hold sweeper driving parity.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start3 = 1'b0;
  logic        abort3 = 1'b0;
  logic        start4 = 1'b0;
  logic        abort4 = 1'b0;
  logic        err_mode = 1'b0;

  logic [2:0]  pat3;
  logic        f3, fn3, busy3, done3, comp_err3;
  logic [7:0]  mask3;
  logic [3:0]  ones3, errc3;

  logic [3:0]  pat4;
  logic        f4, fn4, busy4, done4, comp_err4;
  logic [15:0] mask4;
  logic [4:0]  ones4, errc4;

`ifdef TTS_EXPECT_CHECK_EN
  logic [7:0]  expect3 = 8'h00;
  logic        match3;
  logic [7:0]  mism3;
  logic [15:0] expect4 = 16'h6996;
  logic        match4;
  logic [15:0] mism4;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc;

  always #5 clk = ~clk;

  // Majority DUT model; err_mode ties Fn to F on patterns 3 and 5.
  always_comb begin
    f3  = (pat3[2] & pat3[1]) | (pat3[2] & pat3[0]) | (pat3[1] & pat3[0]);
    fn3 = (err_mode && (pat3 == 3'd3 || pat3 == 3'd5)) ? f3 : ~f3;
    f4  = ^pat4;
    fn4 = ~f4;
  end

  truth_table_sweeper u_dut3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start3),
    .abort        (abort3),
    .pattern      (pat3),
    .f_in         (f3),
    .fn_in        (fn3),
    .busy         (busy3),
    .done         (done3),
    .minterm_mask (mask3),
    .ones_count   (ones3),
    .comp_err     (comp_err3),
    .err_count    (errc3)
`ifdef TTS_EXPECT_CHECK_EN
    ,
    .expect_mask  (expect3),
    .match        (match3),
    .mismatch_mask(mism3)
`endif
  );

  truth_table_sweeper #(
    .N_IN        (4),
    .HOLD_CYCLES (1)
  ) u_dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start4),
    .abort        (abort4),
    .pattern      (pat4),
    .f_in         (f4),
    .fn_in        (fn4),
    .busy         (busy4),
    .done         (done4),
    .minterm_mask (mask4),
    .ones_count   (ones4),
    .comp_err     (comp_err4),
    .err_count    (errc4)
`ifdef TTS_EXPECT_CHECK_EN
    ,
    .expect_mask  (expect4),
    .match        (match4),
    .mismatch_mask(mism4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse start on the 3-input sweeper and count busy cycles (bounded); optionally check pattern steps
  // and poke start mid-sweep, which must be ignored.
  task automatic sweep3(input bit chk, output int unsigned cycles);
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    cycles = 0;
    while (busy3 && cycles < 2000) begin
      if (chk && (cycles % 50) == 0) check("pattern_step", 32'(pat3), cycles / 50);
      start3 = chk && (cycles == 75);
      cycles++;
      @(negedge clk);
    end
    start3 = 1'b0;
  endtask

  task automatic check_zero3(input string tag);
    check({tag, "_pattern"}, 32'(pat3), 0);
    check({tag, "_busy"}, 32'(busy3), 0);
    check({tag, "_done"}, 32'(done3), 0);
    check({tag, "_mask"}, 32'(mask3), 0);
    check({tag, "_ones"}, 32'(ones3), 0);
    check({tag, "_comp_err"}, 32'(comp_err3), 0);
    check({tag, "_err_count"}, 32'(errc3), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_zero3("reset");
    check("reset_busy4", 32'(busy4), 0);
    check("reset_mask4", 32'(mask4), 0);
    rst_n = 1'b1;

    // Full majority sweep with a stray start mid-sweep.
`ifdef TTS_EXPECT_CHECK_EN
    expect3 = 8'hE8;
`endif
    sweep3(1'b1, cyc);
    check("maj_busy_cycles", cyc, 400);
    check("maj_mask", 32'(mask3), 32'h0000_00E8);
    check("maj_ones", 32'(ones3), 4);
    check("maj_comp_err", 32'(comp_err3), 0);
    check("maj_err_count", 32'(errc3), 0);
    check("maj_done", 32'(done3), 1);
    check("maj_pattern_hold", 32'(pat3), 7);
    repeat (5) @(negedge clk);
    check("maj_done_stable", 32'(done3), 1);
    check("maj_mask_stable", 32'(mask3), 32'h0000_00E8);
`ifdef TTS_EXPECT_CHECK_EN
    check("exp_match", 32'(match3), 1);
    check("exp_mism", 32'(mism3), 0);
    expect3 = 8'hE9;
    sweep3(1'b0, cyc);
    check("exp_match_bad", 32'(match3), 0);
    check("exp_mism_bad", 32'(mism3), 32'h01);
`endif

    // Fn tied to F on patterns 3 and 5; restart from DONE.
    err_mode = 1'b1;
    sweep3(1'b0, cyc);
    check("cmp_busy_cycles", cyc, 400);
    check("cmp_comp_err", 32'(comp_err3), 1);
    check("cmp_err_count", 32'(errc3), 2);
    check("cmp_mask", 32'(mask3), 32'h0000_00E8);
    err_mode = 1'b0;

    // Abort after 120 cycles: patterns 0 and 1 sampled, both majority 0.
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    repeat (120) @(negedge clk);
    abort3 = 1'b1;
    @(negedge clk) abort3 = 1'b0;
    check("abort_busy", 32'(busy3), 0);
    check("abort_done", 32'(done3), 0);
    check("abort_pattern", 32'(pat3), 0);
    check("abort_mask", 32'(mask3), 0);
    check("abort_ones", 32'(ones3), 0);
    check("abort_comp_err", 32'(comp_err3), 0);

    // Abort with simultaneous start after 220 cycles: patterns 0..3 sampled and held, abort wins.
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    repeat (220) @(negedge clk);
    abort3 = 1'b1;
    start3 = 1'b1;
    @(negedge clk);
    abort3 = 1'b0;
    start3 = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_pri_busy", 32'(busy3), 0);
    check("abort_pri_pattern", 32'(pat3), 0);
    check("abort_pri_mask", 32'(mask3), 32'h08);
    check("abort_pri_ones", 32'(ones3), 1);

    // Asynchronous reset mid-sweep, then a full sweep.
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    repeat (130) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero3("async_rst");
    @(negedge clk) rst_n = 1'b1;
    sweep3(1'b0, cyc);
    check("post_rst_busy_cycles", cyc, 400);
    check("post_rst_mask", 32'(mask3), 32'h0000_00E8);
    check("post_rst_ones", 32'(ones3), 4);

    // 4-input parity with a one-cycle hold.
    @(negedge clk) start4 = 1'b1;
    @(negedge clk) start4 = 1'b0;
    cyc = 0;
    while (busy4 && cyc < 100) begin
      if (cyc == 0 || cyc == 9 || cyc == 15) check("par_pattern_step", 32'(pat4), cyc);
      cyc++;
      @(negedge clk);
    end
    check("par_busy_cycles", cyc, 16);
    check("par_mask", 32'(mask4), 32'h0000_6996);
    check("par_ones", 32'(ones4), 8);
    check("par_pattern_hold", 32'(pat4), 15);
    check("par_done", 32'(done4), 1);
    check("par_err_count", 32'(errc4), 0);
    check("par_comp_err", 32'(comp_err4), 0);
`ifdef TTS_EXPECT_CHECK_EN
    check("par_match", 32'(match4), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Synthesisable exhaustive stimulus/capture engine for combinational lab DUTs with a true output F and a complement output Fn.
- Generalises the fixed 3-input, 8-step manual sweep to N inputs and a programmable hold time, driven from one clock.
- Captures the DUT truth table as a minterm mask, counts ones, and flags any cycle where Fn is not the complement of F.
- Sits between a bench/top-level controller and the DUT input/output pins.

Parameters:
- N_IN, 3, number of DUT inputs; legal range 1..8. Pattern space is 2^N_IN.
- HOLD_CYCLES, 50, clock cycles each pattern is held; legal range 1..65535.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- abort  input  1  stop the sweep and return to IDLE.
- pattern  output  N_IN  DUT stimulus; bit N_IN-1 is the MSB (x in the 3-input case).
- f_in  input  1  DUT true output.
- fn_in  input  1  DUT complement output.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high after a completed sweep, until the next start or abort.
- minterm_mask  output  2^N_IN  bit k = sampled f_in for pattern k.
- ones_count  output  N_IN+1  number of patterns with sampled f_in=1.
- comp_err  output  1  sticky; set if sampled fn_in == f_in for any pattern.
- err_count  output  N_IN+1  number of patterns with a complement mismatch.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - pattern=0, busy=0, done=0, minterm_mask=0, ones_count=0, comp_err=0, err_count=0.
  - Hold counter is cleared.
- States: IDLE, DRIVE, DONE.
- IDLE or DONE with start=1:
  - Next cycle: state=DRIVE, busy=1, done=0, pattern=0, hold_cnt=0.
  - minterm_mask, ones_count, comp_err and err_count are cleared on the same edge.
- DRIVE:
  - hold_cnt increments each cycle.
  - On the cycle where hold_cnt==HOLD_CYCLES-1, f_in and fn_in are sampled:
    - minterm_mask[pattern] <= f_in.
    - ones_count increments if f_in=1.
    - If fn_in==f_in, err_count increments and comp_err <= 1.
  - On that same edge hold_cnt returns to 0 and pattern increments.
  - Each pattern is therefore held exactly HOLD_CYCLES cycles. Sampling occurs in the last cycle of the hold window so that DUT settling time is HOLD_CYCLES-1 cycles.
- Last pattern:
  - When the sample is taken with pattern == 2^N_IN-1, the next state is DONE, with busy=0 and done=1.
  - pattern holds at 2^N_IN-1; it does not wrap to 0.
  - Busy duration is exactly 2^N_IN*HOLD_CYCLES cycles.
- DONE: all results are held stable until the next start.
- start while in DRIVE: ignored.
- abort=1 (any state):
  - Next cycle: state=IDLE, busy=0, done=0, pattern=0.
  - Partial results are held, not cleared.
  - abort has priority over start in the same cycle.
- HOLD_CYCLES=1: a sample is taken every cycle and the pattern advances every cycle.
- Reset asserted mid-sweep: immediate return to reset values. There is no resume.
- Counter widths: N_IN+1 bits hold 2^N_IN without overflow.

Optional Feature:
- Macro: TTS_EXPECT_CHECK_EN.
- When defined:
  - Adds input expect_mask [2^N_IN], sampled at start.
  - Adds outputs match (1) and mismatch_mask [2^N_IN].
  - On entry to DONE: mismatch_mask = minterm_mask XOR captured expect_mask, and match = (mismatch_mask==0).
  - Both outputs reset to 0 and are cleared on start.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Defaults, DUT F = majority(x,y,z), Fn = ~F, start pulse:
  - pattern steps 0..7, 50 cycles each, busy for 400 cycles.
  - minterm_mask=8'b11101000, ones_count=4, comp_err=0, done=1.
- Defaults, DUT with Fn tied to F on patterns 3 and 5 only -> comp_err=1, err_count=2.
- N_IN=4, HOLD_CYCLES=1, F = parity, start:
  - busy for 16 cycles.
  - minterm_mask=16'h6996, ones_count=8.
  - pattern holds at 15 in DONE.
- abort asserted at cycle 120 of a default sweep:
  - IDLE next cycle, busy=0, done=0, pattern=0.
  - minterm_mask bits 0..1 valid (2 patterns sampled); ones_count equals the number of 1s among them.
- rst_n pulsed low mid-DRIVE (asynchronously, between edges) -> all outputs 0 immediately; a following start performs a full sweep.
- TTS_EXPECT_CHECK_EN defined, expect_mask=8'b11101000 against a majority DUT -> match=1. Then expect_mask=8'b11101001 -> match=0, mismatch_mask=8'b00000001.
